// File: rtl/trade_order_gen_pkg.sv
// Shared types and default widths for the trade order generator.
// FSM state and order side enums live here so the bench can reuse them.
package trade_pkg;

  localparam int DATA_W       = 16;
  localparam int QTY_W        = 8;
  localparam int POS_HEADROOM = 4;
  localparam int POS_W        = QTY_W + POS_HEADROOM;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, COOLDOWN} ord_state_e;
  typedef enum logic {SIDE_BUY = 1'b0, SIDE_SELL = 1'b1} side_e;

endpackage

// File: rtl/trade_order_gen_if.sv
// Order handshake and fill/reject acknowledgement toward the execution link.
// The generator is the master; the exchange side is the slave.
interface trade_order_gen_if #(
  parameter int data_width = 16,
  parameter int qty_width  = 8
) ();

  logic                  order_valid;
  logic                  order_ready;
  logic                  order_side;
  logic [data_width-1:0] order_price;
  logic [qty_width-1:0]  order_qty;
  logic                  ack_valid;
  logic                  ack_filled;

  modport master (
    output order_valid, order_side, order_price, order_qty,
    input  order_ready, ack_valid, ack_filled
  );

  modport slave (
    input  order_valid, order_side, order_price, order_qty,
    output order_ready, ack_valid, ack_filled
  );

endinterface

// File: rtl/trade_cycle_timer.sv
// Loadable down-counter shared by the ack timeout and the cooldown.
// expired marks the final counted cycle, so a load of N spans N cycles.
module trade_cycle_timer #(
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [cnt_w-1:0] load_value,
  output logic             expired
);

  logic [cnt_w-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of 0 behaves like 1: the owner still leaves after one cycle.
  assign expired = (count <= cnt_w'(1));

endmodule

// File: rtl/trade_order_gen.sv
// Turns qualified buy/sell pulses into single orders, tracks net position,
// enforces the position limit, ack timeout and post-order cooldown.
module trade_order_gen
  import trade_pkg::*;
#(
  parameter int                          data_width      = DATA_W,
  parameter int                          qty_width       = QTY_W,
  parameter logic [qty_width-1:0]        order_qty       = qty_width'(10),
  parameter logic signed [qty_width+3:0] max_position    = (qty_width + 4)'(100),
  parameter int                          ack_timeout     = 64,
  parameter int                          cooldown_cycles = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_valid_sma,
  input  logic                          buy_signal,
  input  logic                          sell_signal,
  input  logic [data_width-1:0]         price,
  trade_order_gen_if.master             ord,
  output logic signed [qty_width+3:0]   position,
  output logic                          busy,
  output logic                          timeout_pulse,
  output logic [15:0]                   drop_count
);

  localparam int PW = qty_width + POS_HEADROOM;
  localparam logic signed [PW-1:0] QTY_POS   = $signed({{POS_HEADROOM{1'b0}}, order_qty});
  localparam logic [CNT_W-1:0]     ACK_LOAD  = CNT_W'(ack_timeout);
  localparam logic [CNT_W-1:0]     COOL_LOAD = CNT_W'(cooldown_cycles);

  ord_state_e       state, next_state;
  logic             timer_load, timer_expired;
  logic [CNT_W-1:0] timer_value;
  logic             latch_order, pos_update, timeout_set;

  // One extra bit so position +/- qty can never wrap before the compare.
  logic signed [PW:0] pos_ext, qty_ext, lim_ext;
  logic               buy_ok, sell_ok, candidate, permitted, accept, drop;

  assign pos_ext   = position;
  assign qty_ext   = QTY_POS;
  assign lim_ext   = max_position;
  assign buy_ok    = (pos_ext + qty_ext) <= lim_ext;
  assign sell_ok   = (pos_ext - qty_ext) >= -lim_ext;
  assign candidate = data_valid_sma && (buy_signal ^ sell_signal);
  assign permitted = buy_signal ? buy_ok : sell_ok;
  assign accept    = (state == IDLE) && candidate && permitted;
  assign drop      = data_valid_sma && (buy_signal || sell_signal) && !accept;

  trade_cycle_timer #(.cnt_w(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // busy and order_valid are registered from next_state so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      ord.order_valid <= 1'b0;
    end else begin
      state           <= next_state;
      busy            <= (next_state != IDLE);
      ord.order_valid <= (next_state == SEND);
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (accept) next_state = SEND;
      SEND:     if (ord.order_valid && ord.order_ready) next_state = WAIT_ACK;
      WAIT_ACK: if (ord.ack_valid || timer_expired) next_state = COOLDOWN;
      COOLDOWN: if (timer_expired) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    latch_order = 1'b0;
    timer_load  = 1'b0;
    timer_value = COOL_LOAD;
    pos_update  = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      IDLE: latch_order = accept;
      SEND: begin
        if (ord.order_valid && ord.order_ready) begin
          timer_load  = 1'b1;
          timer_value = ACK_LOAD;
        end
      end
      WAIT_ACK: begin
        // An ack arriving on the expiry cycle wins over the timeout.
        if (ord.ack_valid) begin
          timer_load = 1'b1;
          pos_update = ord.ack_filled;
        end else if (timer_expired) begin
          timer_load  = 1'b1;
          timeout_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: only control and datapath flops are reset; there is no memory here to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord.order_side  <= SIDE_BUY;
      ord.order_price <= '0;
      ord.order_qty   <= '0;
      position        <= '0;
      timeout_pulse   <= 1'b0;
      drop_count      <= '0;
    end else begin
      timeout_pulse <= timeout_set;
      if (latch_order) begin
        ord.order_side  <= buy_signal ? SIDE_BUY : SIDE_SELL;
        ord.order_price <= price;
        ord.order_qty   <= order_qty;
      end
      if (pos_update) begin
        position <= (ord.order_side == SIDE_SELL) ? position - QTY_POS : position + QTY_POS;
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_trade_order_gen.sv
// Directed bench for trade_order_gen: handshake, backpressure, position limit,
// ack timeout, drop counting and asynchronous reset.
module tb_trade_order_gen;
  import trade_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    data_valid_sma = 1'b0;
  logic                    buy_signal = 1'b0;
  logic                    sell_signal = 1'b0;
  logic [DATA_W-1:0]       price = '0;
  logic signed [POS_W-1:0] position;
  logic                    busy;
  logic                    timeout_pulse;
  logic [15:0]             drop_count;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  trade_order_gen_if #(.data_width(DATA_W), .qty_width(QTY_W)) ord ();

  trade_order_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_valid_sma (data_valid_sma),
    .buy_signal     (buy_signal),
    .sell_signal    (sell_signal),
    .price          (price),
    .ord            (ord),
    .position       (position),
    .busy           (busy),
    .timeout_pulse  (timeout_pulse),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n === 1'b1 && ord.order_valid === 1'b1 && ord.order_ready === 1'b1) hs_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    data_valid_sma = 1'b0;
    buy_signal     = 1'b0;
    sell_signal    = 1'b0;
    ord.ack_valid  = 1'b0;
    ord.ack_filled = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic pulse_signal(input logic b, input logic s, input logic [DATA_W-1:0] p);
    data_valid_sma = 1'b1;
    buy_signal     = b;
    sell_signal    = s;
    price          = p;
    @(negedge clk);
    data_valid_sma = 1'b0;
    buy_signal     = 1'b0;
    sell_signal    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_wait: busy=%b after %0d cycles, want 0", tag, busy, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one order with ready held high, ack it, and return once idle again.
  task automatic do_order(input logic b, input logic [DATA_W-1:0] p, input logic fill);
    pulse_signal(b, !b, p);
    checks++;
    if (ord.order_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_issue: order_valid=%b want 1", ord.order_valid);
    end
    @(negedge clk);
    ord.ack_valid  = 1'b1;
    ord.ack_filled = fill;
    @(negedge clk);
    ord.ack_valid  = 1'b0;
    ord.ack_filled = 1'b0;
    wait_idle("order");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ord.order_ready = 1'b0;
    #12;
    checks++;
    if ({ord.order_valid, busy, timeout_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: valid/busy/timeout=%b want 000",
               {ord.order_valid, busy, timeout_pulse});
    end
    checks++;
    if (position !== 12'sd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: position=%0d drop=%0d want 0 0", position, drop_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_buy_fill();
    ord.order_ready = 1'b1;
    pulse_signal(1'b1, 1'b0, 16'd5000);
    checks++;
    if ({ord.order_valid, ord.order_side, ord.order_price, ord.order_qty} !==
        {1'b1, 1'b0, 16'd5000, 8'd10}) begin
      failures++;
      $display("FAIL buy_order: valid=%b side=%b price=%0d qty=%0d want 1 0 5000 10",
               ord.order_valid, ord.order_side, ord.order_price, ord.order_qty);
    end
    @(negedge clk);
    checks++;
    if (ord.order_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL buy_accept: valid=%b busy=%b want 0 1", ord.order_valid, busy);
    end
    ord.ack_valid  = 1'b1;
    ord.ack_filled = 1'b1;
    @(negedge clk);
    ord.ack_valid  = 1'b0;
    ord.ack_filled = 1'b0;
    checks++;
    if (position !== 12'sd10) begin
      failures++;
      $display("FAIL buy_position: position=%0d want 10", position);
    end
    // COOLDOWN was entered at the last edge; 15 more edges keep it busy.
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL cooldown_hold: busy=%b want 1 after 15 cooldown cycles", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cooldown_end: busy=%b want 0 after 16 cooldown cycles", busy);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    ord.order_ready = 1'b0;
    pulse_signal(1'b0, 1'b1, 16'd4321);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ord.order_valid, ord.order_side, ord.order_price, ord.order_qty} !==
          {1'b1, 1'b1, 16'd4321, 8'd10}) begin
        failures++;
        $display("FAIL stall_hold_%0d: valid=%b side=%b price=%0d qty=%0d want 1 1 4321 10",
                 i, ord.order_valid, ord.order_side, ord.order_price, ord.order_qty);
      end
      @(negedge clk);
    end
    hs0 = hs_cnt;
    ord.order_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ord.order_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: valid=%b busy=%b want 0 1", ord.order_valid, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hs_cnt - hs0 !== 1) begin
      failures++;
      $display("FAIL stall_transfers: transfers=%0d want 1", hs_cnt - hs0);
    end
    ord.ack_valid  = 1'b1;
    ord.ack_filled = 1'b0;
    @(negedge clk);
    ord.ack_valid  = 1'b0;
    checks++;
    if (position !== 12'sd10) begin
      failures++;
      $display("FAIL reject_position: position=%0d want 10", position);
    end
    wait_idle("reject");
  endtask

  task automatic test_position_limit();
    do_reset();
    ord.order_ready = 1'b1;
    for (int i = 0; i < 10; i++) do_order(1'b1, DATA_W'(1000 + i), 1'b1);
    checks++;
    if (position !== 12'sd100) begin
      failures++;
      $display("FAIL limit_fill: position=%0d want 100", position);
    end
    pulse_signal(1'b1, 1'b0, 16'd2000);
    checks++;
    if ({ord.order_valid, busy} !== 2'b00 || drop_count !== 16'd1) begin
      failures++;
      $display("FAIL limit_block: valid=%b busy=%b drop=%0d want 0 0 1",
               ord.order_valid, busy, drop_count);
    end
    do_order(1'b0, 16'd2100, 1'b1);
    checks++;
    if (position !== 12'sd90) begin
      failures++;
      $display("FAIL limit_sell: position=%0d want 90", position);
    end
  endtask

  task automatic test_timeout();
    int hit = -1;
    logic early = 1'b0;
    pulse_signal(1'b1, 1'b0, 16'd3000);
    @(negedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) begin
        hit = k;
        break;
      end
    end
    checks++;
    if (hit !== 64) begin
      failures++;
      $display("FAIL timeout_latency: pulse after %0d cycles want 64", hit);
    end
    @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b0 || position !== 12'sd90) begin
      failures++;
      $display("FAIL timeout_after: pulse=%b position=%0d want 0 90", timeout_pulse, position);
    end
    wait_idle("timeout");

    // Ack sampled on the same edge where the timer would expire.
    pulse_signal(1'b1, 1'b0, 16'd3001);
    @(negedge clk);
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL race_pre: early_pulse=%b busy=%b want 0 1", early, busy);
    end
    ord.ack_valid  = 1'b1;
    ord.ack_filled = 1'b1;
    @(negedge clk);
    ord.ack_valid  = 1'b0;
    ord.ack_filled = 1'b0;
    checks++;
    if (timeout_pulse !== 1'b0 || position !== 12'sd100) begin
      failures++;
      $display("FAIL race_ack_wins: pulse=%b position=%0d want 0 100", timeout_pulse, position);
    end
    @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b0) begin
      failures++;
      $display("FAIL race_no_late_pulse: pulse=%b want 0", timeout_pulse);
    end
    wait_idle("race");
  endtask

  task automatic test_drops();
    pulse_signal(1'b1, 1'b1, 16'd100);
    checks++;
    if ({ord.order_valid, busy} !== 2'b00 || drop_count !== 16'd2) begin
      failures++;
      $display("FAIL drop_both: valid=%b busy=%b drop=%0d want 0 0 2",
               ord.order_valid, busy, drop_count);
    end
    pulse_signal(1'b0, 1'b1, 16'd200);
    @(negedge clk);
    pulse_signal(1'b1, 1'b0, 16'd300);
    checks++;
    if (drop_count !== 16'd3 || busy !== 1'b1 || ord.order_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_wait_ack: drop=%0d busy=%b valid=%b want 3 1 0",
               drop_count, busy, ord.order_valid);
    end
    ord.ack_valid  = 1'b1;
    ord.ack_filled = 1'b0;
    @(negedge clk);
    ord.ack_valid  = 1'b0;
    wait_idle("drop");
    buy_signal = 1'b1;
    repeat (2) @(negedge clk);
    buy_signal = 1'b0;
    checks++;
    if (drop_count !== 16'd3 || ord.order_valid !== 1'b0 || position !== 12'sd100) begin
      failures++;
      $display("FAIL drop_unqualified: drop=%0d valid=%b position=%0d want 3 0 100",
               drop_count, ord.order_valid, position);
    end
  endtask

  task automatic test_async_reset();
    ord.order_ready = 1'b0;
    pulse_signal(1'b0, 1'b1, 16'd777);
    checks++;
    if (ord.order_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: valid=%b want 1", ord.order_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ord.order_valid, busy} !== 2'b00 || position !== 12'sd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL areset_immediate: valid=%b busy=%b position=%0d drop=%0d want 0 0 0 0",
               ord.order_valid, busy, position, drop_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ord.order_ready = 1'b1;
    @(negedge clk);
    do_order(1'b1, 16'd555, 1'b1);
    checks++;
    if (position !== 12'sd10) begin
      failures++;
      $display("FAIL areset_resume: position=%0d want 10", position);
    end
  endtask

  initial begin
    test_reset();
    test_buy_fill();
    test_backpressure();
    test_position_limit();
    test_timeout();
    test_drops();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
